// File: rtl/router_port_ctrl_if.sv
// Signal bundle between router_fsm / output FIFOs and router_port_ctrl.
// clr_tout and tout_flag exist only when ROUTER_TOUT_STATUS_EN is defined.
interface router_port_ctrl_if;
   logic       detect_add;
   logic [1:0] data_in;
   logic       write_enb_reg;
   logic       read_enb_0;
   logic       read_enb_1;
   logic       read_enb_2;
   logic       empty_0;
   logic       empty_1;
   logic       empty_2;
   logic       full_0;
   logic       full_1;
   logic       full_2;
   logic [2:0] write_enb;
   logic       fifo_full;
   logic       vld_out_0;
   logic       vld_out_1;
   logic       vld_out_2;
   logic       soft_reset_0;
   logic       soft_reset_1;
   logic       soft_reset_2;
`ifdef ROUTER_TOUT_STATUS_EN
   logic       clr_tout;
   logic [2:0] tout_flag;
`endif

   modport master (
      output detect_add, data_in, write_enb_reg,
      output read_enb_0, read_enb_1, read_enb_2,
      output empty_0, empty_1, empty_2, full_0, full_1, full_2,
      input  write_enb, fifo_full, vld_out_0, vld_out_1, vld_out_2,
      input  soft_reset_0, soft_reset_1, soft_reset_2
`ifdef ROUTER_TOUT_STATUS_EN
      , output clr_tout
      , input  tout_flag
`endif
   );

   modport slave (
      input  detect_add, data_in, write_enb_reg,
      input  read_enb_0, read_enb_1, read_enb_2,
      input  empty_0, empty_1, empty_2, full_0, full_1, full_2,
      output write_enb, fifo_full, vld_out_0, vld_out_1, vld_out_2,
      output soft_reset_0, soft_reset_1, soft_reset_2
`ifdef ROUTER_TOUT_STATUS_EN
      , input  clr_tout
      , output tout_flag
`endif
   );
endinterface

// File: rtl/router_port_ctrl.sv
// Port-side controller of the 1x3 router: address latch, FIFO write decode, full mux,
// valid outputs and per-port read timeout. ROUTER_TOUT_STATUS_EN adds sticky timeout flags.
module router_port_ctrl #(
   parameter int unsigned TIMEOUT = 30,
   parameter int unsigned CNT_W   = 5
) (
   input logic               clock,
   input logic               resetn,
   router_port_ctrl_if.slave bus
);
   localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

   logic [1:0]       addr_q;
   logic [2:0]       vld;
   logic [2:0]       rd;
   logic [2:0]       idle;
   logic [2:0]       write_enb;
   logic             fifo_full;
   logic [CNT_W-1:0] cnt_q [3];
   logic [CNT_W-1:0] cnt_d [3];
   logic [2:0]       soft_reset_q;
   logic [2:0]       soft_reset_d;

   assign vld  = ~{bus.empty_2, bus.empty_1, bus.empty_0};
   assign rd   = {bus.read_enb_2, bus.read_enb_1, bus.read_enb_0};
   assign idle = vld & ~rd;

   // Decode uses the already latched address, so a header cycle never steers its own write.
   always_comb begin
      write_enb = 3'b000;
      fifo_full = 1'b0;
      case (addr_q)
         2'd0: begin
            write_enb = {2'b00, bus.write_enb_reg};
            fifo_full = bus.full_0;
         end
         2'd1: begin
            write_enb = {1'b0, bus.write_enb_reg, 1'b0};
            fifo_full = bus.full_1;
         end
         2'd2: begin
            write_enb = {bus.write_enb_reg, 2'b00};
            fifo_full = bus.full_2;
         end
         default: ;
      endcase
   end

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         cnt_d[i]        = '0;
         soft_reset_d[i] = 1'b0;
         if (idle[i]) begin
            if (cnt_q[i] == CntLast) begin
               soft_reset_d[i] = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         addr_q       <= 2'b11;
         soft_reset_q <= 3'b000;
         for (int i = 0; i < 3; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         if (bus.detect_add) begin
            addr_q <= bus.data_in;
         end
         soft_reset_q <= soft_reset_d;
         for (int i = 0; i < 3; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

`ifdef ROUTER_TOUT_STATUS_EN
   logic [2:0] tout_flag_q;

   // A new timeout beats a clear arriving on the same edge.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         tout_flag_q <= 3'b000;
      end else begin
         tout_flag_q <= (bus.clr_tout ? 3'b000 : tout_flag_q) | soft_reset_d;
      end
   end

   assign bus.tout_flag = tout_flag_q;
`endif

   assign bus.write_enb    = write_enb;
   assign bus.fifo_full    = fifo_full;
   assign bus.vld_out_0    = vld[0];
   assign bus.vld_out_1    = vld[1];
   assign bus.vld_out_2    = vld[2];
   assign bus.soft_reset_0 = soft_reset_q[0];
   assign bus.soft_reset_1 = soft_reset_q[1];
   assign bus.soft_reset_2 = soft_reset_q[2];
endmodule

// File: doc/router_port_ctrl.md
Name: router_port_ctrl

Overview:
- Port-side controller between router_fsm and the three output FIFOs of the 1x3 router.
- Latches the destination address on the header byte and decodes write_enb_reg into a one-hot per-FIFO write enable.
- Muxes the selected FIFO's full flag back to the FSM and generates vld_out_x from the FIFO empty flags.
- Runs a per-port read-timeout timer that pulses soft_reset_x when a destination does not drain its FIFO in time.

Parameters:
TIMEOUT, 30, consecutive unread-valid cycles before soft_reset_x pulses (legal 2..2**CNT_W)
CNT_W, 5, timeout counter width

Ports:
clock  input  1  system clock; all state updates on rising edge
resetn  input  1  synchronous active-low reset
detect_add  input  1  from router_fsm; header cycle, latch data_in
data_in  input  2  destination address (0,1,2 valid; 3 invalid)
write_enb_reg  input  1  from router_fsm; write current byte to selected FIFO
read_enb_0  input  1  destination 0 read strobe
read_enb_1  input  1  destination 1 read strobe
read_enb_2  input  1  destination 2 read strobe
empty_0  input  1  FIFO 0 empty
empty_1  input  1  FIFO 1 empty
empty_2  input  1  FIFO 2 empty
full_0  input  1  FIFO 0 full
full_1  input  1  FIFO 1 full
full_2  input  1  FIFO 2 full
write_enb  output  3  one-hot FIFO write enable
fifo_full  output  1  full flag of the addressed FIFO, to router_fsm
vld_out_0  output  1  FIFO 0 holds data
vld_out_1  output  1  FIFO 1 holds data
vld_out_2  output  1  FIFO 2 holds data
soft_reset_0  output  1  registered one-cycle timeout pulse, port 0
soft_reset_1  output  1  registered one-cycle timeout pulse, port 1
soft_reset_2  output  1  registered one-cycle timeout pulse, port 2

Behaviour:
- Reset (resetn=0 at rising edge):
  - addr_q=2'b11; cnt_0..2=0; soft_reset_0..2=0.
  - Consequently write_enb=3'b000 and fifo_full=0 until the next header.
- Address latch: detect_add=1 at an edge -> addr_q<=data_in. Otherwise addr_q holds.
- write_enb (combinational from addr_q):
  - write_enb_reg=1 and addr_q=0/1/2 -> 3'b001/3'b010/3'b100.
  - Otherwise 3'b000, including addr_q=3.
- Header/write overlap: detect_add and write_enb_reg high in the same cycle -> write_enb uses the previously latched addr_q (zero latency from the register only).
- fifo_full (combinational): full_0/full_1/full_2 for addr_q=0/1/2; 0 for addr_q=3.
- vld_out_x = ~empty_x, combinational, unaffected by reset.
- Per-port timer x, evaluated each edge:
  - idle_x = vld_out_x & ~read_enb_x.
  - idle_x=0 -> cnt_x<=0, soft_reset_x<=0.
  - idle_x=1 and cnt_x<TIMEOUT-1 -> cnt_x<=cnt_x+1, soft_reset_x<=0.
  - idle_x=1 and cnt_x==TIMEOUT-1 -> cnt_x<=0, soft_reset_x<=1. The pulse is visible for exactly one cycle after the TIMEOUT-th consecutive idle cycle.
  - If the FIFO is still non-empty and unread after the pulse, counting restarts from 0; the next pulse comes TIMEOUT cycles later.
  - A single read_enb_x cycle anywhere in the window restarts the count.
- The three ports are fully independent; simultaneous pulses on several ports are allowed.
- resetn=0 mid-count clears the counter and any pending or active pulse at that edge.
- Counter never wraps: the compare at TIMEOUT-1 forces it to 0.

Optional Feature:
ROUTER_TOUT_STATUS_EN:
- Defined:
  - Adds input clr_tout (1 bit) and output tout_flag (3 bits).
  - tout_flag[x] is sticky, set at the same edge soft_reset_x is set.
  - Cleared by resetn=0 or by clr_tout=1 at an edge.
  - Set wins over clear in the same cycle.
- Not defined: ports are absent and no flag logic is built. Core behaviour is identical either way.

Test Plan:
- Reset: resetn=0 for 1 edge with full_1=1, write_enb_reg=1 -> write_enb=000, fifo_full=0, soft_reset_0..2=0.
- Address decode: detect_add=1, data_in=2'b01, then write_enb_reg=1 with full_1=1 -> write_enb=010, fifo_full=1. Repeat with data_in=2'b11 -> write_enb=000, fifo_full=0.
- Timeout: empty_2=0, read_enb_2=0 held for 30 cycles -> soft_reset_2=1 exactly 1 cycle after the 30th edge, then 0. Ports 0 and 1 stay 0.
- Read restarts timer: empty_0=0; read_enb_0=1 on cycle 20 of idle, then idle 29 more cycles -> no pulse. The 30th idle cycle after the read -> pulse.
- Mid-count reset: port 1 idle for 29 cycles, resetn=0 at edge 29 -> no pulse; count restarts from 0 after reset.
- With ROUTER_TOUT_STATUS_EN: port 0 timeout -> tout_flag=001 held; clr_tout=1 on the same edge as a port 2 pulse -> tout_flag=100.
